pipe_issue: RTL and testbench

Instruction issue stage that sits directly upstream of the 3-stage ALU/store pipeline. It buffers packed instruction words in a small FIFO and decodes each one into the RS_1/RS_2/RD/func/addr fields the pipeline consumes. It detects read-after-write hazards against recently issued destinations and inserts bubbles until they clear. It also keeps issue and stall statistics.

---
 rtl/pipe_issue.sv | 216 +++++++++++++++++++++
 tb/tb_pipe_issue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue.sv
`default_nettype none
// ============================================================================
// Module   : pipe_issue
// Purpose  : Issue stage feeding the 3-stage ALU/store pipeline. Buffers
//            packed instruction words in a small FIFO, decodes the head word
//            into RS_1/RS_2/RD/func/addr, holds it back while it reads a
//            register written by an instruction still in flight (RAW hazard)
//            and keeps saturating issue/stall statistics.
// Ports    : clk_1        - clock, all state on its rising edge
//            rst          - synchronous active-high reset
//            INSTR        - {func[21:20], RD[19:16], RS_1[15:12],
//                            RS_2[11:8], addr[7:0]}
//            instr_valid  - INSTR valid this cycle
//            instr_ready  - FIFO has room (from occupancy only)
//            issue_en     - pipeline advance; 0 freezes the stage
//            RS_1/RS_2/RD/func/addr - registered issued fields
//            ISSUE_VALID  - 1 = real instruction, 0 = bubble
//            fifo_count   - FIFO occupancy
//            issue_cnt    - issued instructions (saturating)
//            stall_cnt    - hazard bubble cycles (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_issue #(
    parameter int DEPTH     = 4,
    parameter int HAZ_DEPTH = 2
) (
    input  logic                     clk_1,
    input  logic                     rst,
    input  logic [21:0]              INSTR,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     issue_en,
    output logic [3:0]               RS_1,
    output logic [3:0]               RS_2,
    output logic [3:0]               RD,
    output logic [1:0]               func,
    output logic [7:0]               addr,
    output logic                     ISSUE_VALID,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issue_cnt,
    output logic [15:0]              stall_cnt
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [15:0]      c_SAT  = 16'hFFFF;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [21:0]          r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;

    // Scoreboard: entry 0 is the most recent issue slot.
    logic [HAZ_DEPTH-1:0] r_sb_v;
    logic [3:0]           r_sb_rd [HAZ_DEPTH];

    logic [3:0]           r_rs1;
    logic [3:0]           r_rs2;
    logic [3:0]           r_rd;
    logic [1:0]           r_func;
    logic [7:0]           r_addr;
    logic                 r_issue_valid;
    logic [15:0]          r_issue_cnt;
    logic [15:0]          r_stall_cnt;

    // ------------------------------------------------------------------
    // Head decode and control
    // ------------------------------------------------------------------
    logic [21:0]          w_head;
    logic [3:0]           w_head_rd;
    logic [3:0]           w_head_rs1;
    logic [3:0]           w_head_rs2;
    logic                 w_empty;
    logic                 w_hazard;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_stall;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_rd  = w_head[19:16];
    assign w_head_rs1 = w_head[15:12];
    assign w_head_rs2 = w_head[11:8];

    assign w_empty     = (r_count == '0);
    // Ready is taken from the count alone: a full FIFO never accepts a word,
    // even on a cycle where the head is popping.
    assign instr_ready = (r_count < c_FULL);
    assign w_push      = instr_valid && instr_ready;

    // RAW check against every in-flight destination; func and RD=0 get no
    // special treatment.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_sb_v[i] && ((r_sb_rd[i] == w_head_rs1) ||
                              (r_sb_rd[i] == w_head_rs2))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_pop   = issue_en && !w_empty && !w_hazard;
    assign w_stall = issue_en && !w_empty &&  w_hazard;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_1) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= INSTR;
        end
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are c_AW bits wide, so wrap modulo DEPTH is implicit.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: advances with the pipeline, bubbles shift in as invalid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_sb_v <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                r_sb_rd[i] <= '0;
            end
        end else if (issue_en) begin
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                r_sb_v[i]  <= r_sb_v[i-1];
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
            r_sb_v[0]  <= w_pop;
            r_sb_rd[0] <= w_pop ? w_head_rd : 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Issue registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_func        <= '0;
            r_addr        <= '0;
            r_issue_valid <= 1'b0;
        end else if (issue_en) begin
            if (w_pop) begin
                r_func        <= w_head[21:20];
                r_rd          <= w_head_rd;
                r_rs1         <= w_head_rs1;
                r_rs2         <= w_head_rs2;
                r_addr        <= w_head[7:0];
                r_issue_valid <= 1'b1;
            end else begin
                r_rs1         <= '0;
                r_rs2         <= '0;
                r_rd          <= '0;
                r_func        <= '0;
                r_addr        <= '0;
                r_issue_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics, saturating at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && (r_issue_cnt != c_SAT)) begin
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != c_SAT)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign RS_1        = r_rs1;
    assign RS_2        = r_rs2;
    assign RD          = r_rd;
    assign func        = r_func;
    assign addr        = r_addr;
    assign ISSUE_VALID = r_issue_valid;
    assign fifo_count  = r_count;
    assign issue_cnt   = r_issue_cnt;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_issue
// Purpose  : Self-checking bench for pipe_issue. A queue-based model of the
//            issue stage is compared against the DUT on every cycle, and
//            directed scenarios pin the model with hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_issue;

    localparam int DEPTH     = 4;
    localparam int HAZ_DEPTH = 2;

    logic        clk_1 = 1'b0;
    logic        rst;
    logic [21:0] INSTR;
    logic        instr_valid;
    logic        instr_ready;
    logic        issue_en;
    logic [3:0]  RS_1;
    logic [3:0]  RS_2;
    logic [3:0]  RD;
    logic [1:0]  func;
    logic [7:0]  addr;
    logic        ISSUE_VALID;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    always #5 clk_1 = ~clk_1;

    pipe_issue #(
        .DEPTH     (DEPTH),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .INSTR       (INSTR),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .issue_en    (issue_en),
        .RS_1        (RS_1),
        .RS_2        (RS_2),
        .RD          (RD),
        .func        (func),
        .addr        (addr),
        .ISSUE_VALID (ISSUE_VALID),
        .fifo_count  (fifo_count),
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] dut_log [$];   // addr of each new issue seen on the DUT

    function automatic logic [21:0] mk(input int f, input int rd,
                                       input int rs1, input int rs2,
                                       input int a);
        return {f[1:0], rd[3:0], rs1[3:0], rs2[3:0], a[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a queue of pending words plus the list of destinations that
    // were issued within the last HAZ_DEPTH advancing cycles (-1 = bubble).
    // ------------------------------------------------------------------
    logic [21:0] m_q [$];
    int          m_hist [$];
    bit          m_live = 1'b0;
    logic [21:0] m_word;
    bit          m_valid;
    int          m_issue;
    int          m_stall;

    always @(posedge clk_1) begin : model
        bit          acc;
        bit          haz;
        logic [21:0] h;
        if (rst) begin
            m_q.delete();
            m_hist.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_issue = 0;
            m_stall = 0;
            m_live  = 1'b1;
        end else begin
            acc = instr_valid && (m_q.size() < DEPTH);
            if (issue_en) begin
                if (m_q.size() > 0) begin
                    h   = m_q[0];
                    haz = 1'b0;
                    foreach (m_hist[k]) begin
                        if (m_hist[k] >= 0 && (m_hist[k] == int'(h[15:12]) ||
                                               m_hist[k] == int'(h[11:8])))
                            haz = 1'b1;
                    end
                    if (!haz) begin
                        void'(m_q.pop_front());
                        m_word  = h;
                        m_valid = 1'b1;
                        m_hist.push_front(int'(h[19:16]));
                        if (m_issue < 65535) m_issue++;
                    end else begin
                        m_word  = '0;
                        m_valid = 1'b0;
                        m_hist.push_front(-1);
                        if (m_stall < 65535) m_stall++;
                    end
                end else begin
                    m_word  = '0;
                    m_valid = 1'b0;
                    m_hist.push_front(-1);
                end
                while (m_hist.size() > HAZ_DEPTH) void'(m_hist.pop_back());
            end
            if (acc) m_q.push_back(INSTR);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1);
    endtask

    // Offer a word from a negedge and hold it until the DUT takes it.
    task automatic push(input logic [21:0] w);
        bit done;
        done        = 1'b0;
        INSTR       = w;
        instr_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            if (instr_ready) done = 1'b1;
            @(negedge clk_1);
        end
        instr_valid = 1'b0;
        INSTR       = '0;
        if (!done) begin
            n_chk++;
            $display("FAIL push_timeout: word %0h never accepted, required acceptance", w);
        end
    endtask

    task automatic check_log(input string nm, input int first, input int n);
        chk({nm, "_count"}, dut_log.size(), n);
        for (int i = 0; i < n && i < dut_log.size(); i++) begin
            chk($sformatf("%s_order%0d", nm, i), dut_log[i], first + i);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        INSTR       = '0;
        issue_en    = 1'b0;
        fork
            begin : compare
                logic [15:0] prev;
                prev = '0;
                forever begin
                    @(negedge clk_1);
                    if (m_live) begin
                        chk("instr_ready", instr_ready, (m_q.size() < DEPTH));
                        chk("fifo_count",  fifo_count,  m_q.size());
                        chk("ISSUE_VALID", ISSUE_VALID, m_valid);
                        chk("func",        func,        m_word[21:20]);
                        chk("RD",          RD,          m_word[19:16]);
                        chk("RS_1",        RS_1,        m_word[15:12]);
                        chk("RS_2",        RS_2,        m_word[11:8]);
                        chk("addr",        addr,        m_word[7:0]);
                        chk("issue_cnt",   issue_cnt,   m_issue);
                        chk("stall_cnt",   stall_cnt,   m_stall);
                        if (ISSUE_VALID && issue_cnt != prev) dut_log.push_back(addr);
                        prev = issue_cnt;
                    end
                end
            end
            begin : stimulus
                // ---- Reset with a word offered throughout
                instr_valid = 1'b1;
                INSTR       = mk(0, 9, 9, 9, 77);
                issue_en    = 1'b1;
                idle(2);
                rst         = 1'b0;
                instr_valid = 1'b0;
                INSTR       = '0;
                chk("rst_fifo_count", fifo_count, 0);
                chk("rst_ready",      instr_ready, 1);
                chk("rst_valid",      ISSUE_VALID, 0);
                chk("rst_fields",     {func, RD, RS_1, RS_2, addr}, 0);
                chk("rst_counts",     {issue_cnt, stall_cnt}, 0);
                idle(3);
                chk("rst_no_retain",  fifo_count, 0);
                chk("rst_no_issue",   issue_cnt, 0);

                // ---- Independent stream
                dut_log.delete();
                push(mk(0, 1, 5, 3, 125));
                chk("ind_latency", ISSUE_VALID, 0);
                push(mk(1, 2, 6, 4, 126));
                chk("ind_first_valid", ISSUE_VALID, 1);
                chk("ind_first_addr",  addr, 125);
                push(mk(0, 3, 7, 5, 127));
                chk("ind_second_addr", addr, 126);
                idle(1);
                chk("ind_third_addr",  addr, 127);
                chk("ind_third_rd",    RD, 3);
                idle(1);
                chk("ind_idle_bubble", ISSUE_VALID, 0);
                chk("ind_issue_cnt",   issue_cnt, 3);
                chk("ind_stall_cnt",   stall_cnt, 0);
                check_log("ind", 125, 3);

                // ---- RAW hazard
                idle(3);
                dut_log.delete();
                push(mk(0, 1, 5, 3, 125));
                push(mk(1, 2, 1, 4, 126));
                chk("raw_first_valid", ISSUE_VALID, 1);
                chk("raw_first_addr",  addr, 125);
                idle(1);
                chk("raw_bubble1_valid", ISSUE_VALID, 0);
                chk("raw_bubble1_fields", {func, RD, RS_1, RS_2, addr}, 0);
                idle(1);
                chk("raw_bubble2_valid", ISSUE_VALID, 0);
                idle(1);
                chk("raw_second_valid", ISSUE_VALID, 1);
                chk("raw_second_fields", {func, RD, RS_1, RS_2, addr},
                    {2'd1, 4'd2, 4'd1, 4'd4, 8'd126});
                chk("raw_stall_cnt", stall_cnt, 2);
                chk("raw_issue_cnt", issue_cnt, 5);

                // ---- Full FIFO while frozen
                idle(3);
                issue_en = 1'b0;
                dut_log.delete();
                fork
                    begin
                        for (int i = 0; i < 5; i++) push(mk(0, 8, 9, 10, 200 + i));
                    end
                    begin
                        idle(6);
                        chk("full_count", fifo_count, 4);
                        chk("full_ready", instr_ready, 0);
                        issue_en = 1'b1;
                        idle(1);
                        chk("full_ready_after_pop", instr_ready, 1);
                        chk("full_count_after_pop", fifo_count, 3);
                    end
                join
                idle(7);
                check_log("full", 200, 5);
                chk("full_issue_cnt", issue_cnt, 10);

                // ---- Mid-operation reset
                idle(2);
                push(mk(0, 1, 2, 2, 10));
                idle(1);
                issue_en = 1'b0;
                for (int i = 0; i < 3; i++) push(mk(0, 5, 6, 7, 30 + i));
                chk("mid_queued", fifo_count, 3);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                chk("mid_count_cleared", fifo_count, 0);
                chk("mid_counts_cleared", {issue_cnt, stall_cnt}, 0);
                issue_en = 1'b1;
                dut_log.delete();
                push(mk(0, 4, 1, 1, 50));
                idle(1);
                chk("mid_no_bubble_valid", ISSUE_VALID, 1);
                chk("mid_no_bubble_addr",  addr, 50);
                chk("mid_issue_cnt", issue_cnt, 1);
                chk("mid_stall_cnt", stall_cnt, 0);

                // ---- Wrap-around with a freeze mid-stream
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                dut_log.delete();
                fork
                    begin
                        for (int i = 0; i < 10; i++) push(mk(0, 3, 4, 5, 120 + i));
                    end
                    begin
                        idle(4);
                        issue_en = 1'b0;
                        idle(3);
                        issue_en = 1'b1;
                    end
                join
                idle(8);
                check_log("wrap", 120, 10);
                chk("wrap_issue_cnt", issue_cnt, 10);
                chk("wrap_stall_cnt", stall_cnt, 0);

                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        join
    end

endmodule
`default_nettype wire
